// File: rtl/arm_mul_pkg.sv
// Shared types and helpers for the iterative multiply/multiply-accumulate unit.
//   mul_op_t    : operation encoding as presented on mul_op
//   mul_state_t : sequencer states
//   calc_iters  : CALC iterations for a given multiplier slice width
//   cnt_width   : iteration counter width (never zero)
package arm_mul_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'd0,
    MLA  = 2'd1,
    MULL = 2'd2,
    MLAL = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  function automatic int calc_iters(input int bpc);
    return 32 / bpc;
  endfunction

  function automatic int cnt_width(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/arm_mul_seq_if.sv
// Request/response bundle between register-read, the multiply unit and writeback.
//   request : in_valid/in_ready, mul_op, mul_signed, op1, op2, acc_lo, acc_hi,
//             rd_lo_in, rd_hi_in, flush
//   response: out_valid/out_ready, res_lo, res_hi, is_long, rd_lo_out,
//             rd_hi_out, flags_nz ({N,Z})
// master = pipeline side driving requests, slave = the multiply unit.
interface arm_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mul_op;
  logic        mul_signed;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] acc_lo;
  logic [31:0] acc_hi;
  logic [3:0]  rd_lo_in;
  logic [3:0]  rd_hi_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        is_long;
  logic [3:0]  rd_lo_out;
  logic [3:0]  rd_hi_out;
  logic [1:0]  flags_nz;

  modport master (
    output in_valid, mul_op, mul_signed, op1, op2, acc_lo, acc_hi,
           rd_lo_in, rd_hi_in, flush, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, is_long, rd_lo_out,
           rd_hi_out, flags_nz
  );

  modport slave (
    input  in_valid, mul_op, mul_signed, op1, op2, acc_lo, acc_hi,
           rd_lo_in, rd_hi_in, flush, out_ready,
    output in_ready, out_valid, res_lo, res_hi, is_long, rd_lo_out,
           rd_hi_out, flags_nz
  );
endinterface

// File: rtl/arm_mul_step.sv
// One partial-product step: prod_next = prod + (mcand * chunk) << (count*BITS_PER_CYCLE).
//   mcand     : 32-bit multiplicand magnitude
//   chunk     : current low slice of the multiplier
//   prod      : running 64-bit product
//   count     : iteration index (selects the slice weight)
//   prod_next : updated product, modulo 2^64
module arm_mul_step #(
  parameter int BITS_PER_CYCLE = 8,
  parameter int CNT_W          = 2
) (
  input  logic [31:0]               mcand,
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  logic [63:0]               prod,
  input  logic [CNT_W-1:0]          count,
  output logic [63:0]               prod_next
);
  logic [63:0] pp;
  logic [31:0] sh;

  assign pp        = {32'b0, mcand} * 64'(chunk);
  assign sh        = 32'(count) * 32'(BITS_PER_CYCLE);
  assign prod_next = prod + (pp << sh);
endmodule

// File: rtl/arm_mul_seq.sv
// Iterative MUL/MLA/UMULL/SMULL/UMLAL/SMLAL unit for the execute stage.
// Operands are taken as magnitudes, multiplied BITS_PER_CYCLE multiplier bits
// per CALC cycle, then sign-corrected and accumulated in ACC; results are held
// in DONE until the consumer takes them.
//   clk, rst : clock, synchronous active-high reset
//   bus      : arm_mul_seq_if.slave (request, response and flush)
module arm_mul_seq
  import arm_mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8,
  parameter bit EARLY_TERM     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  arm_mul_seq_if.slave  bus
);
  localparam int ITERS = calc_iters(BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(ITERS);

  mul_state_t state, state_next;

  mul_op_t           op_r;
  logic              long_r;
  logic              neg_r;
  logic [31:0]       mcand_r, mplier_r, acc_lo_r, acc_hi_r;
  logic [3:0]        rd_lo_r, rd_hi_r;
  logic [63:0]       prod_r, prod_next;
  logic [CNT_W-1:0]  cnt_r;

  logic [31:0]       res_lo_q, res_hi_q;
  logic [1:0]        nz_q;
  logic              long_q;
  logic [3:0]        rd_lo_q, rd_hi_q;

  logic              ready, accept, calc_last;
  logic [31:0]       mplier_shr;
  logic              in_long, in_sgn;
  logic [63:0]       signed_prod, acc_add, sum;

  assign ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  // flush wins over a request presented in the same cycle
  assign accept = bus.in_valid && ready && !bus.flush;

  assign mplier_shr = mplier_r >> BITS_PER_CYCLE;
  // stop after the last slice, or early once no multiplier bits remain
  assign calc_last  = (cnt_r == CNT_W'(ITERS - 1)) ||
                      (EARLY_TERM && (mplier_shr == '0));

  assign in_long = bus.mul_op[1];
  assign in_sgn  = bus.mul_signed && in_long;

  arm_mul_step #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (CNT_W)
  ) u_step (
    .mcand     (mcand_r),
    .chunk     (mplier_r[BITS_PER_CYCLE-1:0]),
    .prod      (prod_r),
    .count     (cnt_r),
    .prod_next (prod_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_next = CALC;
        CALC: if (calc_last) state_next = ACC;
        ACC:  state_next = DONE;
        DONE: begin
          if (accept)             state_next = CALC;
          else if (bus.out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    signed_prod = neg_r ? (64'd0 - prod_r) : prod_r;
    acc_add     = '0;
    if (op_r == MLAL)     acc_add = {acc_hi_r, acc_lo_r};
    else if (op_r == MLA) acc_add = {32'b0, acc_lo_r};
    sum = signed_prod + acc_add;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= MUL;
      long_r   <= 1'b0;
      neg_r    <= 1'b0;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_lo_r <= '0;
      acc_hi_r <= '0;
      rd_lo_r  <= '0;
      rd_hi_r  <= '0;
      prod_r   <= '0;
      cnt_r    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      nz_q     <= '0;
      long_q   <= 1'b0;
      rd_lo_q  <= '0;
      rd_hi_q  <= '0;
    end else begin
      if (accept) begin
        op_r     <= mul_op_t'(bus.mul_op);
        long_r   <= in_long;
        neg_r    <= in_sgn && (bus.op1[31] ^ bus.op2[31]);
        // 0x80000000 negates to itself, which is the correct unsigned magnitude
        mcand_r  <= (in_sgn && bus.op1[31]) ? (32'd0 - bus.op1) : bus.op1;
        mplier_r <= (in_sgn && bus.op2[31]) ? (32'd0 - bus.op2) : bus.op2;
        acc_lo_r <= bus.acc_lo;
        acc_hi_r <= bus.acc_hi;
        rd_lo_r  <= bus.rd_lo_in;
        rd_hi_r  <= bus.rd_hi_in;
        prod_r   <= '0;
        cnt_r    <= '0;
      end else if (state == CALC) begin
        prod_r   <= prod_next;
        mplier_r <= mplier_shr;
        cnt_r    <= cnt_r + 1'b1;
      end

      // a flushed ACC leaves the previous result visible
      if (state == ACC && !bus.flush) begin
        res_lo_q <= sum[31:0];
        res_hi_q <= long_r ? sum[63:32] : 32'b0;
        nz_q     <= long_r ? {sum[63], sum == 64'd0} : {sum[31], sum[31:0] == 32'd0};
        long_q   <= long_r;
        rd_lo_q  <= rd_lo_r;
        rd_hi_q  <= rd_hi_r;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == DONE);
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.flags_nz  = nz_q;
  assign bus.is_long   = long_q;
  assign bus.rd_lo_out = rd_lo_q;
  assign bus.rd_hi_out = rd_hi_q;
endmodule

// File: doc/arm_mul_seq.md
Name: arm_mul_seq

Overview:
Iterative multiply/multiply-accumulate unit for the execute stage. It is the neighbouring stage that feeds operands to the combinational MAC datapath and drives results and flags toward writeback.
- Handles MUL, MLA, UMULL/SMULL and UMLAL/SMLAL in multiple cycles.
- Uses valid/ready handshakes on both sides, so the pipeline stalls while a multiply is in flight.
- Supports flush for squashed instructions.

Parameters:
- BITS_PER_CYCLE, 8: multiplier (op2) bits consumed per CALC cycle. Legal values are 1, 2, 4, 8, 16, 32. ITERS = 32/BITS_PER_CYCLE.
- EARLY_TERM, 1: when 1, CALC ends as soon as the remaining multiplier magnitude bits are all zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request from register-read stage
- in_ready  out  1  unit can accept a request this cycle
- mul_op  in  2  0=MUL, 1=MLA, 2=MULL (64-bit), 3=MLAL (64-bit accumulate)
- mul_signed  in  1  signed operands (long forms only; ignored for MUL/MLA)
- op1  in  32  Rm
- op2  in  32  Rs (multiplier)
- acc_lo  in  32  Rn (MLA) or RdLo (MLAL)
- acc_hi  in  32  RdHi (MLAL only)
- rd_lo_in  in  4  destination tag, passed through
- rd_hi_in  in  4  destination tag, passed through
- flush  in  1  kill the in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- res_lo  out  32  result bits [31:0]
- res_hi  out  32  result bits [63:32]; 0 for MUL/MLA
- is_long  out  1  res_hi must be written
- rd_lo_out  out  4  registered rd_lo_in
- rd_hi_out  out  4  registered rd_hi_in
- flags_nz  out  2  {N,Z}. C and V are not produced; the CPSR logic keeps them unchanged.

Behaviour:
- FSM states: IDLE, CALC, ACC, DONE.
- Reset:
  - state goes to IDLE.
  - out_valid=0, in_ready=1.
  - res_lo, res_hi, flags_nz, rd_* and is_long are all 0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). The unit accepts back-to-back operations.
- Accept cycle (in_valid && in_ready):
  - Latch the operation, tags and accumulators.
  - Latch |op1| and |op2| as 32-bit magnitudes when signed and long; store the result sign = sign(op1) XOR sign(op2).
  - Clear the 64-bit product register and the iteration counter; go to CALC.
- CALC:
  - Each cycle, product += (|op1| * low BITS_PER_CYCLE bits of multiplier) << (count*BITS_PER_CYCLE).
  - The multiplier shifts right by BITS_PER_CYCLE; count increments.
  - Leave CALC after ITERS iterations, or, when EARLY_TERM=1, after the first iteration whose shifted-out remainder is all zero.
  - At least 1 iteration is always performed.
- ACC:
  - Negate the 64-bit product if signed and the result sign is 1.
  - Add {acc_hi,acc_lo} for MLAL, or {32'b0,acc_lo} for MLA. All addition is modulo 2^64.
  - MUL/MLA keep the low 32 bits and force res_hi=0.
  - Compute N and Z:
    - 32-bit ops: N=bit31, Z=(low32==0).
    - Long ops: N=bit63, Z=(all 64 bits==0).
  - Register all outputs; go to DONE.
- DONE:
  - out_valid=1; outputs stay stable until out_ready.
  - If out_ready and no new accept: go to IDLE, out_valid=0 next cycle.
  - If out_ready and accept in the same cycle: go to CALC with the new operands.
- Latency: out_valid rises in cycle accept+N+2, where N is the number of CALC iterations (ITERS without early termination; 4 with the default).
- flush:
  - Takes effect in any state and has priority over in_valid and out_ready.
  - Next cycle: state=IDLE, out_valid=0. Data outputs are unspecified (don't-care) but not X-propagating; they hold their last value.
  - A request presented in the same cycle as flush is not accepted.
- rst during any state behaves the same as flush and also clears the data outputs.
- Signed magnitude of 0x80000000 is 0x80000000 (unsigned 32-bit). SMULL 0x80000000*0x80000000 = 0x40000000_00000000.

Decomposition:
- Package arm_mul_pkg:
  - mul_op_t enum (MUL, MLA, MULL, MLAL).
  - mul_state_t enum (IDLE, CALC, ACC, DONE).
  - localparam ITERS derivation helper.
- Sub-module arm_mul_step: combinational partial-product step.
  - Inputs: |op1|, multiplier chunk, product, count.
  - Output: next product.
  - Instantiated once in CALC.

Test Plan:
- MUL op1=3, op2=5, EARLY_TERM=1, BITS_PER_CYCLE=8 -> 1 iteration; out_valid at accept+3; res_lo=15, res_hi=0, N=0, Z=0.
- MLA op1=op2=0xFFFFFFFF, acc_lo=1, EARLY_TERM=0 -> out_valid at accept+6; res_lo=0x00000002, N=0, Z=0, is_long=0.
- SMULL op1=0xFFFFFFFE (-2), op2=3 -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA, N=1, Z=0.
- UMLAL op1=0x80000000, op2=2, acc_hi=1, acc_lo=0xFFFFFFFF -> res_hi=0x00000002, res_lo=0xFFFFFFFF, N=0.
- MUL op1=0, op2=0x12345678 -> Z=1, N=0. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Then out_ready=1 with a new in_valid -> new operation accepted the same cycle.
- Flush during the 2nd CALC cycle -> out_valid never rises; in_ready=1 next cycle. Next op MUL 7*6 -> res_lo=42 with correct tags.
